// File: rtl/ysyx_22040895_imem_bridge.sv
// Instruction fetch bridge: PC request -> single-outstanding valid/ready read -> held word for the IFU.
// Optional alignment/response checking is enabled by defining YSYX_22040895_IFETCH_ERR_CHECK_EN.
module ysyx_22040895_imem_bridge #(
    parameter int                ADDR_W     = 64,
    parameter int                INST_W     = 32,
    parameter logic [INST_W-1:0] RESET_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_ce_i,
    input  logic              flush_i,
    input  logic              ifu_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [INST_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // arvalid is never dropped before arready, and araddr holds until that edge.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_DROP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   araddr_q;
    logic [ADDR_W-1:0]   inst_addr_q;
    logic [INST_W-1:0]   inst_q;
    logic                err_q;
    logic                drop_pending_q;
    logic                misaligned;
    logic                resp_err;

`ifdef YSYX_22040895_IFETCH_ERR_CHECK_EN
    assign misaligned = (req_addr_i[1:0] != 2'b00);
    assign resp_err   = (rresp_i != 2'b00);
`else
    logic unused_err_inputs;
    assign unused_err_inputs = ^rresp_i;
    assign misaligned        = 1'b0;
    assign resp_err          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_ce_i && !flush_i) state_d = misaligned ? S_HOLD : S_ADDR;
            end
            S_ADDR: begin
                if (arready_i) state_d = (drop_pending_q || flush_i) ? S_DROP : S_DATA;
            end
            S_DATA: begin
                if (rvalid_i)     state_d = flush_i ? S_IDLE : S_HOLD;
                else if (flush_i) state_d = S_DROP;
            end
            S_HOLD: begin
                if (ifu_ready_i || flush_i) state_d = S_IDLE;
            end
            S_DROP: begin
                if (rvalid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            araddr_q       <= '0;
            inst_addr_q    <= '0;
            inst_q         <= RESET_INST;
            err_q          <= 1'b0;
            drop_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req_ce_i && !flush_i) begin
                        araddr_q <= req_addr_i;
                        // A misaligned request is answered locally with a NOP and the error flag.
                        if (misaligned) begin
                            inst_addr_q <= req_addr_i;
                            inst_q      <= RESET_INST;
                            err_q       <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (rvalid_i && !flush_i) begin
                        inst_q      <= resp_err ? RESET_INST : rdata_i;
                        inst_addr_q <= araddr_q;
                        err_q       <= resp_err;
                    end
                end
                S_HOLD: begin
                    if (ifu_ready_i || flush_i) begin
                        inst_q <= RESET_INST;
                        err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
            // A flush seen before the address handshake poisons the response still owed by the bus.
            if (state_d == S_IDLE)                  drop_pending_q <= 1'b0;
            else if (state_q == S_ADDR && flush_i) drop_pending_q <= 1'b1;
        end
    end

    assign araddr_o     = araddr_q;
    assign arvalid_o    = (state_q == S_ADDR);
    assign rready_o     = (state_q == S_DATA) || (state_q == S_DROP);
    assign inst_valid_o = (state_q == S_HOLD);
    assign busy_o       = (state_q != S_IDLE);
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_ysyx_22040895_imem_bridge.sv
// Directed bench for the imem fetch bridge: cycle-level bus driving plus a scoreboard
// that checks every instruction handed to the IFU.
module tb_ysyx_22040895_imem_bridge;

    localparam int             AW  = 64;
    localparam int             IW  = 32;
    localparam logic [IW-1:0]  NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] req_addr_i = '0;
    logic          req_ce_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          ifu_ready_i = 1'b0;
    logic [IW-1:0] inst_o;
    logic [AW-1:0] inst_addr_o;
    logic          inst_valid_o;
    logic          busy_o;
    logic          err_o;
    logic [AW-1:0] araddr_o;
    logic          arvalid_o;
    logic          arready_i = 1'b0;
    logic [IW-1:0] rdata_i = '0;
    logic [1:0]    rresp_i = 2'b00;
    logic          rvalid_i = 1'b0;
    logic          rready_o;

    int tests = 0;
    int fails = 0;
    logic [IW+AW:0] exp_q[$];
    logic [IW+AW:0] mon_e;

    ysyx_22040895_imem_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .req_addr_i   (req_addr_i),
        .req_ce_i     (req_ce_i),
        .flush_i      (flush_i),
        .ifu_ready_i  (ifu_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compares every instruction the IFU consumes
    always @(negedge clk) begin
        if (!rst && inst_valid_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_inst actual=%h expected=none", inst_o);
            end else if (ifu_ready_i || flush_i) begin
                mon_e = exp_q.pop_front();
                if (ifu_ready_i) begin
                    chk("mon_inst", 64'(inst_o), 64'(mon_e[IW-1:0]));
                    chk("mon_addr", inst_addr_o, mon_e[IW+AW-1:IW]);
                    chk("mon_err", 64'(err_o), 64'(mon_e[IW+AW]));
                end
            end
        end
    end

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, 64'(busy_o), 64'd0);
        chk({name, "_valid"}, 64'(inst_valid_o), 64'd0);
        chk({name, "_arvalid"}, 64'(arvalid_o), 64'd0);
        chk({name, "_inst"}, 64'(inst_o), 64'(NOP));
    endtask

    // driver: full fetch with configurable wait states on each handshake
    task automatic fetch(input logic [63:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input int ar_wait, input int r_wait, input int ifu_wait);
        logic [31:0] exp_inst;
        logic        exp_err;
        exp_inst = data;
        exp_err  = 1'b0;
`ifdef YSYX_22040895_IFETCH_ERR_CHECK_EN
        if (resp != 2'b00) begin
            exp_inst = NOP;
            exp_err  = 1'b1;
        end
`endif
        exp_q.push_back({exp_err, addr, exp_inst});
        req_addr_i = addr;
        req_ce_i   = 1'b1;
        tick();
        req_ce_i   = 1'b0;
        req_addr_i = '1;
        for (int i = 0; i < ar_wait; i++) begin
            chk("ar_wait_valid", 64'(arvalid_o), 64'd1);
            chk("ar_wait_addr", araddr_o, addr);
            tick();
        end
        chk("ar_valid", 64'(arvalid_o), 64'd1);
        chk("ar_addr", araddr_o, addr);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        chk("ar_once", 64'(arvalid_o), 64'd0);
        chk("r_ready", 64'(rready_o), 64'd1);
        for (int i = 0; i < r_wait; i++) begin
            tick();
            chk("r_wait_ready", 64'(rready_o), 64'd1);
            chk("r_wait_valid", 64'(inst_valid_o), 64'd0);
        end
        rvalid_i = 1'b1;
        rdata_i  = data;
        rresp_i  = resp;
        tick();
        rvalid_i = 1'b0;
        rdata_i  = '0;
        rresp_i  = 2'b00;
        chk("hold_valid", 64'(inst_valid_o), 64'd1);
        chk("r_once", 64'(rready_o), 64'd0);
        for (int i = 0; i < ifu_wait; i++) begin
            chk("hold_stable", 64'(inst_o), 64'(exp_inst));
            chk("hold_valid_stay", 64'(inst_valid_o), 64'd1);
            tick();
        end
        ifu_ready_i = 1'b1;
        tick();
        ifu_ready_i = 1'b0;
        chk_idle("after_fetch");
        chk("after_fetch_err", 64'(err_o), 64'd0);
    endtask

    initial begin
        // reset with random bus activity
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr_i  = {$urandom, $urandom};
            req_ce_i    = 1'($urandom_range(0, 1));
            flush_i     = 1'($urandom_range(0, 1));
            ifu_ready_i = 1'($urandom_range(0, 1));
            arready_i   = 1'($urandom_range(0, 1));
            rvalid_i    = 1'($urandom_range(0, 1));
            rdata_i     = $urandom;
            rresp_i     = 2'($urandom_range(0, 3));
            tick();
            chk_idle("reset");
            chk("reset_rready", 64'(rready_o), 64'd0);
            chk("reset_err", 64'(err_o), 64'd0);
            chk("reset_araddr", araddr_o, 64'd0);
            chk("reset_inst_addr", inst_addr_o, 64'd0);
        end
        req_ce_i = 0; flush_i = 0; ifu_ready_i = 0; arready_i = 0; rvalid_i = 0;
        rdata_i = '0; rresp_i = 2'b00; req_addr_i = '0;
        rst = 1'b0;
        tick();

        // zero-wait, backpressure, mixed waits
        fetch(64'h80000000, 32'h00100093, 2'b00, 0, 0, 0);
        fetch(64'h80001000, 32'h00208113, 2'b00, 3, 2, 4);
        fetch(64'h80000004, 32'h0000006f, 2'b00, 1, 0, 1);

        // flush in IDLE suppresses the request
        req_addr_i = 64'h80000010; req_ce_i = 1; flush_i = 1;
        tick();
        req_ce_i = 0; flush_i = 0;
        chk_idle("flush_idle");

        // flush in ADDR before arready: response beat is swallowed
        req_addr_i = 64'h80000020; req_ce_i = 1;
        tick();
        req_ce_i = 0;
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("fa_arvalid_kept", 64'(arvalid_o), 64'd1);
        chk("fa_araddr_kept", araddr_o, 64'h80000020);
        arready_i = 1;
        tick();
        arready_i = 0;
        chk("fa_drop_rready", 64'(rready_o), 64'd1);
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("fa_drop_ignores_flush", 64'(rready_o), 64'd1);
        rvalid_i = 1; rdata_i = 32'hDEADBEEF;
        tick();
        rvalid_i = 0; rdata_i = '0;
        chk_idle("fa_done");

        // flush together with rvalid in DATA
        req_addr_i = 64'h80000030; req_ce_i = 1;
        tick();
        req_ce_i = 0; arready_i = 1;
        tick();
        arready_i = 0; rvalid_i = 1; rdata_i = 32'h12345678; flush_i = 1;
        tick();
        rvalid_i = 0; flush_i = 0; rdata_i = '0;
        chk_idle("fd_rvalid");

        // flush in DATA without rvalid: drains through DROP
        req_addr_i = 64'h80000040; req_ce_i = 1;
        tick();
        req_ce_i = 0; arready_i = 1;
        tick();
        arready_i = 0; flush_i = 1;
        tick();
        flush_i = 0;
        chk("fd_drop_rready", 64'(rready_o), 64'd1);
        chk("fd_drop_busy", 64'(busy_o), 64'd1);
        rvalid_i = 1; rdata_i = 32'hCAFEF00D;
        tick();
        rvalid_i = 0; rdata_i = '0;
        chk_idle("fd_drop_done");

        // flush together with ifu_ready in HOLD: instruction is consumed
        exp_q.push_back({1'b0, 64'h80000050, 32'h00a00513});
        req_addr_i = 64'h80000050; req_ce_i = 1;
        tick();
        req_ce_i = 0; arready_i = 1;
        tick();
        arready_i = 0; rvalid_i = 1; rdata_i = 32'h00a00513;
        tick();
        rvalid_i = 0; rdata_i = '0;
        chk("fh_valid", 64'(inst_valid_o), 64'd1);
        ifu_ready_i = 1; flush_i = 1;
        tick();
        ifu_ready_i = 0; flush_i = 0;
        chk_idle("fh_done");

`ifdef YSYX_22040895_IFETCH_ERR_CHECK_EN
        // misaligned request: no bus access, error NOP
        exp_q.push_back({1'b1, 64'h80000002, NOP});
        req_addr_i = 64'h80000002; req_ce_i = 1;
        tick();
        req_ce_i = 0;
        chk("mis_arvalid", 64'(arvalid_o), 64'd0);
        chk("mis_valid", 64'(inst_valid_o), 64'd1);
        chk("mis_err", 64'(err_o), 64'd1);
        chk("mis_inst", 64'(inst_o), 64'(NOP));
        ifu_ready_i = 1;
        tick();
        ifu_ready_i = 0;
        chk_idle("mis_done");
        chk("mis_err_clr", 64'(err_o), 64'd0);

        // error response
        fetch(64'h80000060, 32'h00b00593, 2'b10, 0, 0, 1);
`endif

        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_imem_bridge.md
Name: ysyx_22040895_imem_bridge

Overview:
- Instruction-memory fetch bridge sitting directly upstream of the IFU.
- Takes the fetch address and chip-enable produced by the PC, runs a single-outstanding read transaction on a valid/ready memory bus, and delivers the returned instruction word, with its address, to the IFU instruction input.
- Discards in-flight or held instructions on a redirect (branch/jump PC select).

Parameters:
- ADDR_W, 64, fetch address width (instruction address bus width)
- INST_W, 32, instruction word width
- RESET_INST, 32'h00000013, value driven on inst_o during reset and when no instruction is held (RV NOP)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_addr_i  input  ADDR_W  fetch address from PC
- req_ce_i  input  1  fetch enable from PC
- flush_i  input  1  redirect: PC select taken this cycle; kill current fetch
- ifu_ready_i  input  1  IFU accepts the held instruction this cycle
- inst_o  output  INST_W  fetched instruction to IFU
- inst_addr_o  output  ADDR_W  address of inst_o
- inst_valid_o  output  1  inst_o/inst_addr_o valid
- busy_o  output  1  high in any state other than IDLE
- err_o  output  1  fetch error flag (see Optional Feature)
- araddr_o  output  ADDR_W  bus read address
- arvalid_o  output  1  bus read-address valid
- arready_i  input  1  bus read-address ready
- rdata_i  input  INST_W  bus read data
- rresp_i  input  2  bus read response (00 = OKAY)
- rvalid_i  input  1  bus read-data valid
- rready_o  output  1  bus read-data ready

Behaviour:
- States: IDLE, ADDR, DATA, HOLD, DROP. All outputs decode from registered state/registers; no combinational path from bus inputs to outputs.
- Reset, sync on rst=1: state=IDLE; arvalid_o=0, rready_o=0, inst_valid_o=0, busy_o=0, err_o=0; araddr_o=0, inst_addr_o=0; inst_o=RESET_INST. rst mid-transaction abandons it with no wait for the bus.
- IDLE: if req_ce_i=1 and flush_i=0, latch req_addr_i into araddr_o and go to ADDR. If flush_i=1, stay in IDLE.
- ADDR: arvalid_o=1. araddr_o is held stable until the handshake; arvalid is never withdrawn.
  - On arready_i=1: go to DATA, or to DROP if a flush is pending or flush_i=1 this cycle.
  - flush_i without arready_i sets drop_pending and stays in ADDR.
- DATA: rready_o=1.
  - On rvalid_i=1 with flush_i=0: capture rdata_i into inst_o and araddr_o into inst_addr_o; go to HOLD.
  - On rvalid_i=1 with flush_i=1: discard the data and go to IDLE.
  - flush_i without rvalid_i: go to DROP.
- DROP: rready_o=1. Wait for rvalid_i, discard the data, go to IDLE. flush_i is ignored here. drop_pending is cleared on entry to IDLE.
- HOLD: inst_valid_o=1 and inst_o stable.
  - On ifu_ready_i=1 or flush_i=1: go to IDLE, inst_valid_o=0 next cycle, inst_o returns to RESET_INST.
  - Simultaneous ifu_ready_i and flush_i: instruction counts as consumed. Same next state.
- Latency: request sampled in IDLE at cycle N; arvalid_o high at N+1. With zero-wait bus (arready at N+1, rvalid at N+2): inst_valid_o high at N+3. Minimum issue interval is 4 cycles (IDLE bubble after HOLD).
- Only one transaction is outstanding at a time. req_addr_i changes outside IDLE are ignored.

Optional Feature:
- Macro: YSYX_22040895_IFETCH_ERR_CHECK_EN.
- Defined:
  - In IDLE, a request with req_addr_i[1:0]!=0 issues no bus access. The block goes straight to HOLD with inst_o=RESET_INST and err_o=1.
  - In DATA, rresp_i!=00 on the rvalid beat gives inst_o=RESET_INST and err_o=1 in HOLD.
  - err_o is valid only with inst_valid_o and clears on leaving HOLD.
- Not defined: rresp_i and address alignment are ignored; err_o is tied 0.

Test Plan:
- Reset: hold rst=1 for 3 cycles with random bus inputs -> all outputs at reset values, inst_o=32'h00000013, every cycle.
- Zero-wait fetch:
  - Stimulus: req_addr_i=64'h80000000, req_ce_i=1 at N; arready=1; rvalid at N+2 with rdata=32'h00100093; ifu_ready=1.
  - Response: arvalid at N+1, araddr=64'h80000000; inst_valid at N+3 with inst_o=32'h00100093, inst_addr_o=64'h80000000; IDLE at N+4.
- Backpressure:
  - Stimulus: arready low for 3 cycles; rvalid delayed 2 cycles; ifu_ready low for 4 cycles.
  - Response: araddr/arvalid stable throughout ADDR; inst_o stable while inst_valid=1; exactly one handshake of each kind.
- Flush in ADDR:
  - Stimulus: flush_i pulse before arready.
  - Response: after arready, response beat (rdata=32'hDEADBEEF) is consumed with rready=1 and never appears on inst_o; inst_valid stays 0; back in IDLE.
- Flush with simultaneous events:
  - Stimulus: flush_i and rvalid_i in the same DATA cycle; separately, flush_i and ifu_ready_i in the same HOLD cycle.
  - Response: no inst_valid in the first case; IDLE next cycle in both.
- With YSYX_22040895_IFETCH_ERR_CHECK_EN:
  - Stimulus: req_addr_i=64'h80000002; separately, rresp=2'b10.
  - Response: no arvalid for the misaligned case; both cases give inst_valid=1, err_o=1, inst_o=32'h00000013.
